mont_result_tx: RTL and testbench
=================================

MONT_RESULT_TX -- requirements
Module: mont_result_tx

Interface
REQ-001 Clocking SHALL be one clock; reset is asynchronous and active-high.
REQ-002 Parameter SIZE_INPUT, default 2048, result operand width in bits.
REQ-003 Parameter WORD_SIZE, default 64, bus word width in bits; SIZE_INPUT SHALL be an integer multiple of WORD_SIZE.
REQ-004 Parameter ITERATION, default SIZE_INPUT/WORD_SIZE (32), data words per frame.
REQ-005 Port clk  input  1  rising-edge clock.
REQ-006 Port reset  input  1  asynchronous active-high reset.
REQ-007 Port load  input  1  single-cycle request to capture result and start a frame.
REQ-008 Port result  input  SIZE_INPUT  finished Montgomery product, sampled only on an accepted load.
REQ-009 Port bus_ready  input  1  downstream can accept the current word.
REQ-010 Port bus  output  WORD_SIZE  outgoing word.
REQ-011 Port bus_valid  output  1  bus holds a valid word.
REQ-012 Port last  output  1  current word is the frame trailer.
REQ-013 Port busy  output  1  frame in progress; load is ignored.
REQ-014 Port done  output  1  one-cycle pulse when the frame completes.

Function
REQ-015 The FSM SHALL have the states IDLE, SEND, CHK and FIN; reset state SHALL be IDLE.
REQ-016 In IDLE with load=1, the block SHALL capture result into a SIZE_INPUT shift register, clear the word counter and checksum, and enter SEND on the next edge.
REQ-017 load SHALL be ignored in every state other than IDLE, with no effect on captured data or counters.
REQ-018 bus_valid SHALL rise in the cycle after the accepted load (latency 1), with bus = result[WORD_SIZE-1:0].
REQ-019 Words SHALL be sent least-significant first: word k = result[(k+1)*WORD_SIZE-1 : k*WORD_SIZE], k = 0..ITERATION-1, matching the operand load order of the multiplier.
REQ-020 A word transfers only on an edge where bus_valid=1 and bus_ready=1.
REQ-021 While bus_valid=1 and bus_ready=0, bus, last and all internal state SHALL hold unchanged.
REQ-022 On each transfer in SEND, the checksum register SHALL be updated as checksum XOR bus, the shift register SHALL shift right by WORD_SIZE, and the 6-bit counter SHALL increment.
REQ-023 On the transfer of word ITERATION-1, the FSM SHALL enter CHK; in CHK, bus SHALL be the checksum and last SHALL be 1.
REQ-024 A data word SHALL never assert last.
REQ-025 On the CHK transfer, the FSM SHALL enter FIN; in FIN, bus_valid SHALL be 0 and done SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-026 busy SHALL be 1 in SEND, CHK and FIN, and 0 in IDLE.
REQ-027 A frame SHALL be exactly ITERATION+1 transfers (33 by default), regardless of back-pressure pattern.
REQ-028 When bus_valid=0, bus SHALL be driven to 0.
REQ-029 A load accepted in the cycle after FIN (back-to-back frames) SHALL start a new frame normally.
REQ-030 The counter SHALL never wrap; it SHALL be cleared on load.

Reset
REQ-031 While reset=1, and immediately on its assertion, the block SHALL drive bus=0, bus_valid=0, last=0, busy=0 and done=0, clear the shift register, counter and checksum, and force the FSM to IDLE.
REQ-032 A reset asserted mid-frame SHALL abort the frame with no done pulse; the first load after reset release SHALL start a fresh frame from word 0.

Verification
REQ-033 result=1, bus_ready=1 -> word0=64'h1, words 1..31=0, trailer=64'h1 with last=1, and done pulsed the cycle after the trailer, 33 transfers in total.
REQ-034 result all ones -> 32 words of 64'hFFFF_FFFF_FFFF_FFFF, trailer=64'h0 with last=1.
REQ-035 result word k = k (k=0..31), bus_ready=0 for 3 cycles while word 5 is presented -> bus=64'h5 held stable for those cycles, transfer on the 4th cycle, trailer=64'h0 (XOR of 0..31).
REQ-036 load pulsed again during word 10 with different data -> frame output unchanged, no restart, exactly one done pulse.
REQ-037 reset asserted while word 10 is presented -> bus_valid=0 and busy=0 immediately, no done pulse; a new load after release -> word0 of the new result is presented one cycle later.

Source files
------------

// File: rtl/mont_result_tx.sv
// mont_result_tx: serialises a finished Montgomery product onto a word-wide
// valid/ready bus. The bus is least-significant word first, and a frame ends
// with an XOR checksum trailer.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   load       single-cycle request to capture result (honoured only in idle)
//   result     SIZE_INPUT-bit operand, sampled on an accepted load
//   bus_ready  downstream accepts the current word
//   bus        outgoing word (0 when bus_valid is low)
//   bus_valid  bus holds a valid word
//   last       current word is the checksum trailer
//   busy       frame in progress
//   done       one-cycle pulse after the trailer transfers

module mont_result_tx #(
    parameter int unsigned SIZE_INPUT = 2048,
    parameter int unsigned WORD_SIZE  = 64,
    parameter int unsigned ITERATION  = SIZE_INPUT / WORD_SIZE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [SIZE_INPUT-1:0] result,
    input  logic                  bus_ready,
    output logic [WORD_SIZE-1:0]  bus,
    output logic                  bus_valid,
    output logic                  last,
    output logic                  busy,
    output logic                  done
);

    // Counter must hold ITERATION after the final data word without wrapping.
    localparam int unsigned CntW = (ITERATION > 63) ? $clog2(ITERATION + 1) : 6;
    localparam logic [CntW-1:0] LastIdx = CntW'(ITERATION - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StChk,
        StFin
    } state_e;

    state_e                state_q, state_d;
    logic [SIZE_INPUT-1:0] shift_q, shift_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [WORD_SIZE-1:0]  csum_q, csum_d;
    logic                  xfer;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
        end
    end

    // Outputs decode from state only, so reset forces them low immediately.
    always_comb begin
        bus       = '0;
        bus_valid = 1'b0;
        last      = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (state_q)
            StIdle: busy = 1'b0;
            StSend: begin
                bus_valid = 1'b1;
                bus       = shift_q[WORD_SIZE-1:0];
            end
            StChk: begin
                bus_valid = 1'b1;
                bus       = csum_q;
                last      = 1'b1;
            end
            StFin: done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    assign xfer = bus_valid & bus_ready;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;
        unique case (state_q)
            StIdle: begin
                if (load) begin
                    shift_d = result;
                    cnt_d   = '0;
                    csum_d  = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (xfer) begin
                    csum_d  = csum_q ^ shift_q[WORD_SIZE-1:0];
                    shift_d = {{WORD_SIZE{1'b0}}, shift_q[SIZE_INPUT-1:WORD_SIZE]};
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == LastIdx) begin
                        state_d = StChk;
                    end
                end
            end
            StChk: begin
                if (xfer) begin
                    state_d = StFin;
                end
            end
            StFin: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_mont_result_tx.sv
module tb_mont_result_tx;

    localparam int SIZE = 2048;
    localparam int W    = 64;
    localparam int N    = SIZE / W;

    logic            clk;
    logic            reset;
    logic            load;
    logic [SIZE-1:0] result;
    logic            bus_ready;
    logic [W-1:0]    bus;
    logic            bus_valid;
    logic            last;
    logic            busy;
    logic            done;

    int checks;
    int errors;

    mont_result_tx #(
        .SIZE_INPUT(SIZE),
        .WORD_SIZE (W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .result   (result),
        .bus_ready(bus_ready),
        .bus      (bus),
        .bus_valid(bus_valid),
        .last     (last),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [SIZE-1:0] res;
        int              stall_word;
        int              stall_cycles;
        int              reload_word;
        logic [W-1:0]    trailer;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the
    // idle cycle that follows FIN, so consecutive calls are back-to-back.
    task automatic run_frame(input vec_t v);
        int           n_xfer;
        int           stalled;
        int           budget;
        logic [W-1:0] exp;
        check("idle_busy", W'(busy), 0);
        load      = 1'b1;
        result    = v.res;
        bus_ready = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("latency_valid", W'(bus_valid), 1);
        check("latency_word0", bus, v.res[W-1:0]);
        n_xfer  = 0;
        stalled = 0;
        budget  = 200;
        while (n_xfer < N + 1 && budget > 0) begin
            exp = (n_xfer < N) ? v.res[n_xfer*W +: W] : v.trailer;
            check("valid", W'(bus_valid), 1);
            check((n_xfer < N) ? "data_word" : "trailer", bus, exp);
            check("last", W'(last), (n_xfer == N) ? 1 : 0);
            check("busy", W'(busy), 1);
            check("done_early", W'(done), 0);
            if (n_xfer == v.stall_word && stalled < v.stall_cycles) begin
                bus_ready = 1'b0;
                stalled++;
            end else begin
                bus_ready = 1'b1;
            end
            if (n_xfer == v.reload_word) begin
                load   = 1'b1;
                result = ~v.res;
            end else begin
                load = 1'b0;
            end
            if (bus_valid && bus_ready) n_xfer++;
            @(negedge clk);
            budget--;
        end
        load = 1'b0;
        check("xfer_count", W'(n_xfer), N + 1);
        check("stall_cycles", W'(stalled), W'(v.stall_cycles));
        check("fin_done", W'(done), 1);
        check("fin_valid", W'(bus_valid), 0);
        check("fin_bus", bus, 0);
        check("fin_busy", W'(busy), 1);
        @(negedge clk);
        check("post_done", W'(done), 0);
        check("post_busy", W'(busy), 0);
        check("post_valid", W'(bus_valid), 0);
    endtask

    logic [SIZE-1:0] pat;

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        load      = 1'b0;
        result    = '0;
        bus_ready = 1'b0;

        for (int k = 0; k < N; k++) pat[k*W +: W] = W'(k);

        // Trailers are hand-computed XORs of the data words.
        vecs[0] = '{res: SIZE'(1), stall_word: -1, stall_cycles: 0, reload_word: -1,
                    trailer: 64'h1};
        vecs[1] = '{res: {SIZE{1'b1}}, stall_word: -1, stall_cycles: 0, reload_word: -1,
                    trailer: 64'h0};
        vecs[2] = '{res: pat, stall_word: 5, stall_cycles: 3, reload_word: -1,
                    trailer: 64'h0};
        vecs[3] = '{res: pat, stall_word: -1, stall_cycles: 0, reload_word: 10,
                    trailer: 64'h0};
        vecs[4] = '{res: {64'h5A, {(SIZE - 2*W){1'b0}}, 64'hA5}, stall_word: 32,
                    stall_cycles: 2, reload_word: -1, trailer: 64'hFF};

        #12;
        check("rst_bus", bus, 0);
        check("rst_valid", W'(bus_valid), 0);
        check("rst_last", W'(last), 0);
        check("rst_busy", W'(busy), 0);
        check("rst_done", W'(done), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run_frame(vecs[i]);

        // Abort mid-frame while word 10 is on the bus.
        load      = 1'b1;
        result    = pat;
        bus_ready = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_abort_word10", bus, 64'hA);
        reset = 1'b1;
        #1;
        check("abort_valid", W'(bus_valid), 0);
        check("abort_busy", W'(busy), 0);
        check("abort_bus", bus, 0);
        check("abort_last", W'(last), 0);
        check("abort_done", W'(done), 0);
        @(negedge clk);
        load = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rst_load_busy", W'(busy), 0);
            check("rst_load_done", W'(done), 0);
        end
        load  = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("release_done", W'(done), 0);
        run_frame(vecs[4]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
